esp_resp_parser: RTL and testbench
==================================

ESP_RESP_PARSER -- requirements
Module: esp_resp_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000000, meaning cycles to wait in WAIT before declaring timeout (minimum 2).
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of the timeout counter; TIMEOUT_CYCLES SHALL fit in CNT_W bits.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 arm  input  1  one-cycle pulse from the command sequencer: start waiting for a response.
REQ-006 rx_data  input  8  byte from the PMOD UART receiver.
REQ-007 rx_valid  input  1  rx_data valid this cycle.
REQ-008 rx_ready  output  1  parser accepts a byte this cycle.
REQ-009 busy  output  1  high while in WAIT.
REQ-010 resp_ok  output  1  one-cycle pulse: line "OK\r\n" received.
REQ-011 resp_err  output  1  one-cycle pulse: line "ERROR\r\n" received.
REQ-012 resp_timeout  output  1  one-cycle pulse: no terminating line within TIMEOUT_CYCLES.

Function
REQ-013 SHALL implement states IDLE and WAIT; all outputs registered except rx_ready.
REQ-014 rx_ready SHALL be 1 whenever rst is low (byte consumed when rx_valid & rx_ready); no backpressure.
REQ-015 IDLE: accepted bytes discarded; arm -> WAIT next cycle, line_pos=0, both match flags set, timer=0.
REQ-016 WAIT: each accepted byte compared at line_pos against "OK\r" (positions 0-2) and "ERROR\r" (positions 0-5); mismatch or position past pattern end clears that pattern's flag.
REQ-017 line_pos SHALL increment per accepted non-'\n' byte and saturate at 15.
REQ-018 On accepted 0x0A: if OK flag set and line_pos==3 -> resp_ok pulse next cycle, go IDLE; else if ERROR flag set and line_pos==6 -> resp_err pulse, go IDLE; else line discarded, line_pos=0, flags re-set, remain WAIT.
REQ-019 Non-matching lines (command echo, "busy p...", blank "\r\n") SHALL be ignored without affecting the timer.
REQ-020 Timer SHALL increment every WAIT cycle; on reaching TIMEOUT_CYCLES-1 with no completing match that cycle -> resp_timeout pulse, go IDLE.
REQ-021 Completing match and timer expiry in same cycle: match SHALL win; resp_timeout not asserted.
REQ-022 arm while in WAIT SHALL restart: timer=0, line_pos=0, flags re-set; byte accepted that cycle discarded.
REQ-023 arm and completing '\n' in same WAIT cycle: arm SHALL win, no result pulse.
REQ-024 At most one of resp_ok/resp_err/resp_timeout SHALL be high in any cycle; each high exactly one cycle per response.
REQ-025 busy SHALL fall in the same cycle a result pulse rises.

Reset
REQ-026 While rst high at a clk edge: state=IDLE, busy=0, resp_ok=0, resp_err=0, resp_timeout=0, timer=0, line_pos=0; rx_ready=0 while rst high.
REQ-027 rst mid-WAIT SHALL abort with no result pulse; a byte in flight is dropped.
REQ-028 After rst deasserts, parser SHALL ignore all bytes until next arm.

Verification (TIMEOUT_CYCLES=1000)
REQ-029 arm, then bytes "AT\r\r\n" "\r\n" "OK\r\n" with gaps -> single resp_ok 1 cycle after final 0x0A; busy 1->0 same cycle; no other pulses.
REQ-030 arm, then "ERROR\r\n" -> single resp_err; "OKAY\r\n" and "OK\n" alone -> no pulse, busy stays 1.
REQ-031 arm, no bytes -> resp_timeout exactly 1000 cycles after arm; busy low thereafter.
REQ-032 arm, "OK\r" then final 0x0A on timer value 999 -> resp_ok only, no resp_timeout.
REQ-033 arm, "OK\r", then rst 1 cycle, then "\n" -> no pulse, busy=0; "OK\r\n" in IDLE without arm -> no pulse.
REQ-034 arm, "OK\r\n" back-to-back at rx_valid every cycle, second arm 500 cycles into a later WAIT -> timeout measured from second arm (1000 cycles).

Source files
------------

// File: rtl/esp_resp_parser.sv
// esp_resp_parser: waits after arm for an "OK\r\n" or "ERROR\r\n" line from the ESP module, or times out
module esp_resp_parser #(
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       busy,
  output logic       resp_ok,
  output logic       resp_err,
  output logic       resp_timeout
);
  typedef enum logic {IDLE, WAIT} state_t;
  localparam logic [7:0] OK_P [4] = '{8'h4F, 8'h4B, 8'h0D, 8'h00};
  localparam logic [7:0] ERR_P [8] = '{8'h45, 8'h52, 8'h52, 8'h4F, 8'h52, 8'h0D, 8'h00, 8'h00};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [3:0] pos, pos_n;
  logic ok_f, err_f, ok_fn, err_fn, ok_p, err_p, to_p, acc;
  assign rx_ready = ~rst;
  assign acc = rx_valid & rx_ready;
  always_comb begin
    state_n = state;
    timer_n = timer;
    pos_n = pos;
    ok_fn = ok_f;
    err_fn = err_f;
    ok_p = 1'b0;
    err_p = 1'b0;
    to_p = 1'b0;
    if (arm) begin
      state_n = WAIT;
      timer_n = '0;
      pos_n = '0;
      ok_fn = 1'b1;
      err_fn = 1'b1;
    end else if (state == WAIT) begin
      timer_n = timer + 1'b1;
      if (acc && rx_data == 8'h0A) begin
        ok_p = ok_f && pos == 4'd3;
        err_p = !ok_p && err_f && pos == 4'd6;
        if (!ok_p && !err_p) begin
          pos_n = '0;
          ok_fn = 1'b1;
          err_fn = 1'b1;
        end
      end else if (acc) begin
        ok_fn = ok_f && pos < 4'd3 && rx_data == OK_P[pos[1:0]];
        err_fn = err_f && pos < 4'd6 && rx_data == ERR_P[pos[2:0]];
        pos_n = pos == 4'd15 ? pos : pos + 4'd1;
      end
      // A completing line beats an expiring timer in the same cycle
      to_p = !ok_p && !err_p && timer == LAST;
      state_n = (ok_p || err_p || to_p) ? IDLE : WAIT;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      pos <= '0;
      ok_f <= 1'b0;
      err_f <= 1'b0;
      busy <= 1'b0;
      resp_ok <= 1'b0;
      resp_err <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      pos <= pos_n;
      ok_f <= ok_fn;
      err_f <= err_fn;
      busy <= state_n == WAIT;
      resp_ok <= ok_p;
      resp_err <= err_p;
      resp_timeout <= to_p;
    end
  end
endmodule

// File: tb/tb_esp_resp_parser.sv
// tb_esp_resp_parser: directed checks of the ESP response parser with TIMEOUT_CYCLES=1000
module tb_esp_resp_parser;
  logic clk = 1'b0, rst = 1'b1, arm = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_ready, busy, resp_ok, resp_err, resp_timeout;
  int pass = 0, total = 0;
  int n_ok = 0, n_err = 0, n_to = 0, n_viol = 0;
  esp_resp_parser #(.TIMEOUT_CYCLES(1000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .arm(arm), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .busy(busy), .resp_ok(resp_ok), .resp_err(resp_err),
    .resp_timeout(resp_timeout)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    n_ok += int'(resp_ok);
    n_err += int'(resp_err);
    n_to += int'(resp_timeout);
    if (int'(resp_ok) + int'(resp_err) + int'(resp_timeout) > 1) n_viol++;
    if ((resp_ok | resp_err | resp_timeout) && busy) n_viol++;
  end
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got == exp) pass++;
    else $display("FAIL %s got %0d expected %0d", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask
  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      repeat (gap) tick();
    end
  endtask
  task automatic wait_timeout(input string tag);
    int early = 0;
    for (int i = 0; i < 999; i++) begin
      tick();
      if (resp_timeout) early++;
    end
    chk({tag, "_early"}, early, 0);
    tick();
    chk({tag, "_pulse"}, int'(resp_timeout), 1);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_ready", int'(rx_ready), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    #1;
    chk("ready", int'(rx_ready), 1);
    send_str("OK\r\n", 0);
    chk("idle_no_arm", n_ok, 0);
    do_arm();
    chk("arm_busy", int'(busy), 1);
    send_str("AT\r\r\n", 2);
    send_str("\r\n", 1);
    send_str("OK\r", 3);
    chk("echo_ignored", int'(busy), 1);
    send(8'h0A);
    chk("ok_pulse", int'(resp_ok), 1);
    chk("ok_busy", int'(busy), 0);
    tick();
    chk("ok_one_cycle", int'(resp_ok), 0);
    do_arm();
    send_str("OKAY\r\n", 1);
    send_str("OK\n", 0);
    tick();
    chk("bad_lines_busy", int'(busy), 1);
    chk("bad_lines_no_ok", n_ok, 1);
    send_str("ERROR\r", 0);
    send(8'h0A);
    chk("err_pulse", int'(resp_err), 1);
    chk("err_busy", int'(busy), 0);
    tick();
    chk("err_one_cycle", int'(resp_err), 0);
    do_arm();
    wait_timeout("to1");
    tick();
    chk("to_one_cycle", int'(resp_timeout), 0);
    do_arm();
    send_str("OK\r", 0);
    repeat (996) tick();
    send(8'h0A);
    chk("race_ok", int'(resp_ok), 1);
    chk("race_no_to", int'(resp_timeout), 0);
    tick();
    chk("race_no_late_to", int'(resp_timeout), 0);
    do_arm();
    send_str("OK\r", 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(8'h0A);
    chk("rst_abort_ok", int'(resp_ok), 0);
    chk("rst_abort_busy", int'(busy), 0);
    send_str("OK\r\n", 0);
    tick();
    chk("post_rst_idle", n_ok, 2);
    do_arm();
    send_str("OK\r", 0);
    rx_data = 8'h0A;
    rx_valid = 1'b1;
    arm = 1'b1;
    tick();
    rx_valid = 1'b0;
    arm = 1'b0;
    chk("arm_wins_ok", int'(resp_ok), 0);
    chk("arm_wins_busy", int'(busy), 1);
    do_arm();
    send_str("OK\r\n", 0);
    chk("b2b_ok", int'(resp_ok), 1);
    do_arm();
    repeat (500) tick();
    do_arm();
    wait_timeout("rearm");
    repeat (3) tick();
    chk("n_ok", n_ok, 3);
    chk("n_err", n_err, 1);
    chk("n_to", n_to, 2);
    chk("exclusive", n_viol, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
